// File: rtl/base_decode_pkg.sv
// Shared types and the binary-to-vector decode function for base_decode_pipe.
package base_decode_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT = 2'd0,
    DEC_THERM  = 2'd1,
    DEC_RANGE  = 2'd2,
    DEC_RSVD   = 2'd3
  } dec_mode_t;

  localparam int unsigned MAX_DEC = 256;

  // Result layout: bit 0 = err, bit i+1 = output line i. Lines at or above dec_w stay 0.
  function automatic logic [MAX_DEC:0] dec_vec(input dec_mode_t mode, input logic [31:0] din,
                                               input int unsigned dec_w);
    logic [MAX_DEC:0] r;
    logic err;
    r   = '0;
    err = (din >= dec_w) || (mode == DEC_RSVD);
    for (int unsigned i = 0; i < MAX_DEC; i++) begin
      if (!err && i < dec_w) begin
        case (mode)
          DEC_ONEHOT: r[i+1] = (i == din);
          DEC_THERM:  r[i+1] = (i <= din);
          DEC_RANGE:  r[i+1] = (i >= din);
          default:    r[i+1] = 1'b0;
        endcase
      end
    end
    r[0] = err;
    return r;
  endfunction

endpackage

// File: rtl/base_skid2.sv
// Two-entry skid buffer: main drives the outputs, skid absorbs one beat of backpressure.
module base_skid2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_din,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_dout
);

  logic             main_v, skid_v;
  logic [width-1:0] main_d, skid_d;
  logic             acc, take;

  assign acc  = i_v & i_r;
  assign take = ~main_v | o_r;   // main empty or draining this edge

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (take) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= acc;
        if (acc) skid_d <= i_din;
      end else begin
        main_v <= acc;
        if (acc) main_d <= i_din;
      end
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_d <= i_din;
    end
  end

  // Ready comes from register state only, so no o_r -> i_r combinational path.
  assign i_r    = ~skid_v & ~reset;
  assign o_v    = main_v;
  assign o_dout = main_v ? main_d : '0;

endmodule

// File: rtl/base_decode_pipe.sv
// Registered, handshaked binary decoder with one-hot/thermometer/range modes and error counting.
module base_decode_pipe
  import base_decode_pkg::*;
#(
  parameter int enc_width = 3,
  parameter int dec_width = 2**enc_width,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:enc_width-1] i_din,
  input  logic [1:0]           i_mode,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:dec_width-1] o_dout,
  output logic                 o_err,
  output logic [cnt_width-1:0] err_cnt,
  input  logic                 err_clr
);

  logic [MAX_DEC:0]   dv;
  logic [dec_width:0] beat, held;
  logic               acc;

  // Decode at acceptance; only {lines, err} travel through the buffer.
  assign dv   = dec_vec(dec_mode_t'(i_mode), 32'(i_din), dec_width);
  assign beat = dv[dec_width:0];
  assign acc  = i_v & i_r;

  generate
    if (dec_width < MAX_DEC) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^dv[MAX_DEC:dec_width+1];
    end
  endgenerate

  base_skid2 #(.width(dec_width + 1)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_v    (i_v),
    .i_r    (i_r),
    .i_din  (beat),
    .o_v    (o_v),
    .o_r    (o_r),
    .o_dout (held)
  );

  generate
    for (genvar i = 0; i < dec_width; i++) begin : g_line
      assign o_dout[i] = held[i+1];
    end
  endgenerate
  assign o_err = held[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (acc && beat[0] && !(&err_cnt))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_base_decode_pipe.sv
// Scoreboard bench for base_decode_pipe: directed corner cases plus randomized traffic and backpressure.
module tb_base_decode_pipe;
  import base_decode_pkg::*;

  localparam int EW = 3;
  localparam int DW = 6;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_v, i_r, o_v, o_r, o_err, err_clr;
  logic [0:EW-1] i_din;
  logic [1:0]    i_mode;
  logic [0:DW-1] o_dout;
  logic [CW-1:0] err_cnt;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW:0]   exp_q[$];
  int            model_cnt = 0;

  base_decode_pipe #(.enc_width(EW), .dec_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_din(i_din), .i_mode(i_mode),
    .o_v(o_v), .o_r(o_r), .o_dout(o_dout), .o_err(o_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: lines packed MSB-first (line 0 leftmost), err in bit 0.
  function automatic logic [DW:0] model(input int d, input int m);
    int v;
    if (d >= DW || m == 3) return {{DW{1'b0}}, 1'b1};
    case (m)
      0:       v = 1 << (DW - 1 - d);
      1:       v = ((1 << DW) - 1) & ~((1 << (DW - 1 - d)) - 1);
      default: v = (1 << (DW - d)) - 1;
    endcase
    return {DW'(v), 1'b0};
  endfunction

  // Scoreboard feed: inputs are stable here, so this is the handshake of the coming edge.
  always @(negedge clk) begin
    #1;
    if (reset) model_cnt = 0;
    else begin
      if (i_v && i_r) exp_q.push_back(model(int'(i_din), int'(i_mode)));
      if (err_clr) model_cnt = 0;
      else if (i_v && i_r && model(int'(i_din), int'(i_mode)) == 1 && model_cnt < (1 << CW) - 1)
        model_cnt++;
    end
  end

  // Monitor: compares every transferred beat and the counter every cycle.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset) begin
      chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
      if (o_v && o_r) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("dout", 32'(o_dout), 32'(e[DW:1]));
          chk("err", 32'(o_err), 32'(e[0]));
        end
      end else if (!o_v) begin
        chk("idle_gate", 32'({o_dout, o_err}), 32'(0));
      end
    end
  end

  task automatic send(input int d, input int m);
    i_v = 1'b1; i_din = EW'(d); i_mode = m[1:0];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (i_r) begin
        @(posedge clk); #1;
        i_v = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    i_v = 1'b0;
    chk("send_timeout", 32'(1), 32'(0));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_v = 1'b0; i_din = '0; i_mode = 2'd0; o_r = 1'b1; err_clr = 1'b0;
    #1;
    chk("rst_ov", 32'(o_v), 32'(0));
    chk("rst_ir", 32'(i_r), 32'(0));
    chk("rst_cnt", 32'(err_cnt), 32'(0));
    chk("rst_dout", 32'({o_dout, o_err}), 32'(0));
    #12 reset = 1'b0;
    @(negedge clk);
    chk("ir_after_rst", 32'(i_r), 32'(1));
    @(posedge clk); #1;

    // one-hot sweep, including the two out-of-range codes
    for (int d = 0; d < 8; d++) send(d, DEC_ONEHOT);
    send(3, DEC_THERM);
    send(3, DEC_RANGE);
    send(0, DEC_RANGE);
    send(5, DEC_THERM);

    // error counting and saturation
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    send(6, DEC_ONEHOT); send(7, DEC_THERM); send(0, DEC_RSVD);
    @(negedge clk); chk("err_cnt_3", 32'(err_cnt), 32'(3));
    @(posedge clk); #1;
    send(6, DEC_RANGE); send(2, DEC_RSVD);
    @(negedge clk); chk("err_sat", 32'(err_cnt), 32'(3));
    @(posedge clk); #1;
    err_clr = 1'b1; send(7, DEC_ONEHOT); err_clr = 1'b0;
    @(negedge clk); chk("clr_wins", 32'(err_cnt), 32'(0));
    @(posedge clk); #1;

    // backpressure: only two beats absorbed, release restores ready after first drain
    cyc(4);
    o_r = 1'b0;
    i_v = 1'b1; i_din = 3'd1; i_mode = DEC_ONEHOT;
    @(negedge clk); chk("bp_ir0", 32'(i_r), 32'(1));
    @(posedge clk); #1; i_din = 3'd2;
    @(negedge clk); chk("latency_ov", 32'(o_v), 32'(1)); chk("bp_ir1", 32'(i_r), 32'(1));
    @(posedge clk); #1; i_din = 3'd3;
    @(negedge clk); chk("bp_ir_low", 32'(i_r), 32'(0));
    @(posedge clk); #1;
    @(negedge clk); chk("bp_hold_ir", 32'(i_r), 32'(0)); chk("bp_hold_ov", 32'(o_v), 32'(1));
    @(posedge clk); #1; o_r = 1'b1;
    @(negedge clk); chk("rel_ir_pre", 32'(i_r), 32'(0));
    @(posedge clk); #1;
    @(negedge clk); chk("rel_ir", 32'(i_r), 32'(1));
    @(posedge clk); #1; i_v = 1'b0;
    send(4, DEC_THERM);

    // randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      i_v     = ($urandom_range(0, 3) != 0);
      i_din   = EW'($urandom_range(0, 7));
      i_mode  = 2'($urandom_range(0, 3));
      o_r     = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    i_v = 1'b0; err_clr = 1'b0; o_r = 1'b1;
    cyc(5);

    // reset with both registers full
    o_r = 1'b0;
    send(7, DEC_ONEHOT);
    send(1, DEC_ONEHOT);
    @(negedge clk); chk("full_ir", 32'(i_r), 32'(0));
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_ov", 32'(o_v), 32'(0));
    chk("mid_rst_out", 32'({o_dout, o_err}), 32'(0));
    chk("mid_rst_cnt", 32'(err_cnt), 32'(0));
    chk("mid_rst_ir", 32'(i_r), 32'(0));
    cyc(2);
    #2 reset = 1'b0;
    o_r = 1'b1;
    @(negedge clk); chk("ir_after_mid_rst", 32'(i_r), 32'(1));
    @(posedge clk); #1;
    send(2, DEC_RANGE);

    cyc(10);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
